// File: rtl/polara_mc_pkg.sv
// polara_mc_pkg: shared types and defaults for the Polara memory-side NoC arbiter.
// Holds the arbiter state enum, header length-field defaults and counter widths.
package polara_mc_pkg;
   typedef enum logic [1:0] {IDLE, HOLD, BODY} arb_state_e;
   localparam int LEN_MSB_DEF = 29;
   localparam int LEN_LSB_DEF = 22;
   localparam int REM_W       = 8;
   localparam int STATS_W     = 16;
endpackage

// File: rtl/polara_rr_pick2.sv
// polara_rr_pick2: two-input round-robin select; preferred port wins when valid.
module polara_rr_pick2 (
   input  logic [1:0] vals,
   input  logic       rr_ptr,
   output logic       winner,
   output logic       any
);
   assign any    = |vals;
   assign winner = vals[rr_ptr] ? rr_ptr : ~rr_ptr;
endmodule

// File: rtl/polara_mem_noc_arb.sv
// polara_mem_noc_arb: whole-packet round-robin arbiter of two NoC requesters onto the memory controller channel.
// Defining POLARA_MEM_ARB_STATS_EN adds saturating per-requester packet counters pkt_cnt0/pkt_cnt1.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
module polara_mem_noc_arb
   import polara_mc_pkg::*;
#(
   parameter int DW      = `NOC_DATA_WIDTH,
   parameter int LEN_MSB = LEN_MSB_DEF,
   parameter int LEN_LSB = LEN_LSB_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] req0_flit_data,
   input  logic          req0_flit_val,
   output logic          req0_flit_rdy,
   input  logic [DW-1:0] req1_flit_data,
   input  logic          req1_flit_val,
   output logic          req1_flit_rdy,
   output logic [DW-1:0] mem_flit_in_data,
   output logic          mem_flit_in_val,
   input  logic          mem_flit_in_rdy,
   output logic          arb_busy,
   output logic          arb_grant
`ifdef POLARA_MEM_ARB_STATS_EN
   ,
   output logic [STATS_W-1:0] pkt_cnt0,
   output logic [STATS_W-1:0] pkt_cnt1
`endif
);
   arb_state_e state_q, state_d;
   logic grant_q, grant_d, rr_q, rr_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic win, any, cur, sel_val, hs, done, open;
   logic [DW-1:0] sel_data;
   logic [LEN_MSB-LEN_LSB:0] len;

   polara_rr_pick2 u_pick (
      .vals   ({req1_flit_val, req0_flit_val}),
      .rr_ptr (rr_q),
      .winner (win),
      .any    (any)
   );

   // Outside IDLE the latched grant owns the channel so packets never interleave.
   assign cur      = (state_q == IDLE) ? win : grant_q;
   assign sel_val  = cur ? req1_flit_val : req0_flit_val;
   assign sel_data = cur ? req1_flit_data : req0_flit_data;
   assign len      = sel_data[LEN_MSB:LEN_LSB];
   assign open     = rst_n & mem_flit_in_rdy & ((state_q != IDLE) | any);

   assign mem_flit_in_val  = rst_n & sel_val;
   assign mem_flit_in_data = sel_data;
   assign req0_flit_rdy    = open & ~cur;
   assign req1_flit_rdy    = open & cur;
   assign arb_busy         = state_q != IDLE;
   assign arb_grant        = grant_q;
   assign hs               = mem_flit_in_val & mem_flit_in_rdy;

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      rr_d    = rr_q;
      rem_d   = rem_q;
      done    = 1'b0;
      case (state_q)
         IDLE, HOLD: begin
            if (hs) begin
               grant_d = cur;
               if (len == '0) begin
                  state_d = IDLE;
                  rr_d    = ~cur;
                  done    = 1'b1;
               end else begin
                  state_d = BODY;
                  rem_d   = REM_W'(len);
               end
            end else if (mem_flit_in_val) begin
               state_d = HOLD;
               grant_d = cur;
            end
         end
         BODY: begin
            if (hs) begin
               rem_d = rem_q - 1'b1;
               if (rem_q == REM_W'(1)) begin
                  state_d = IDLE;
                  rr_d    = ~grant_q;
                  done    = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         rr_q    <= 1'b0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         rr_q    <= rr_d;
         rem_q   <= rem_d;
      end
   end

`ifdef POLARA_MEM_ARB_STATS_EN
   logic [STATS_W-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;

   always_comb begin
      cnt0_d = (done & ~cur & ~&cnt0_q) ? cnt0_q + 1'b1 : cnt0_q;
      cnt1_d = (done &  cur & ~&cnt1_q) ? cnt1_q + 1'b1 : cnt1_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         cnt0_q <= cnt0_d;
         cnt1_q <= cnt1_d;
      end
   end

   assign pkt_cnt0 = cnt0_q;
   assign pkt_cnt1 = cnt1_q;
`else
   logic unused_done;
   assign unused_done = done;
`endif
endmodule

// File: tb/tb_polara_mem_noc_arb.sv
// tb_polara_mem_noc_arb: directed scenario bench for the two-port packet arbiter.
module tb_polara_mem_noc_arb;
   logic clk = 1'b0;
   logic rst_n;
   logic [63:0] d0, d1, md;
   logic v0, v1, r0, r1, mv, mr, busy, grant;
   int pass_cnt = 0;
   int tot_cnt = 0;
   logic [63:0] exp;
`ifdef POLARA_MEM_ARB_STATS_EN
   logic [15:0] pc0, pc1;
`endif

   always #5 clk = ~clk;

   polara_mem_noc_arb dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req0_flit_data   (d0),
      .req0_flit_val    (v0),
      .req0_flit_rdy    (r0),
      .req1_flit_data   (d1),
      .req1_flit_val    (v1),
      .req1_flit_rdy    (r1),
      .mem_flit_in_data (md),
      .mem_flit_in_val  (mv),
      .mem_flit_in_rdy  (mr),
      .arb_busy         (busy),
      .arb_grant        (grant)
`ifdef POLARA_MEM_ARB_STATS_EN
      ,
      .pkt_cnt0         (pc0),
      .pkt_cnt1         (pc1)
`endif
   );

   function automatic logic [63:0] hdr(input logic [7:0] n, input logic [15:0] tag);
      return {tag, 16'h0, 2'b00, n, 22'h0};
   endfunction

   task automatic test_reset;
      rst_n = 1'b0; v0 = 1'b1; v1 = 1'b1; mr = 1'b1;
      d0 = hdr(8'd3, 16'h0001); d1 = hdr(8'd3, 16'h0002);
      #1;
      tot_cnt++; if (mv !== 1'b0) $display("FAIL rst_val got=%b exp=0", mv); else pass_cnt++;
      tot_cnt++; if (r0 !== 1'b0) $display("FAIL rst_rdy0 got=%b exp=0", r0); else pass_cnt++;
      tot_cnt++; if (r1 !== 1'b0) $display("FAIL rst_rdy1 got=%b exp=0", r1); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
      tot_cnt++; if (grant !== 1'b0) $display("FAIL rst_grant got=%b exp=0", grant); else pass_cnt++;
      repeat (2) @(negedge clk);
      v0 = 1'b0; v1 = 1'b0; rst_n = 1'b1;
      #1;
      tot_cnt++; if (mv !== 1'b0) $display("FAIL idle_val got=%b exp=0", mv); else pass_cnt++;
   endtask

   task automatic test_single;
      @(negedge clk); v0 = 1'b1; d0 = hdr(8'd3, 16'h00A0); mr = 1'b1; #1;
      tot_cnt++; if (mv !== 1'b1) $display("FAIL single_hdr_val got=%b exp=1", mv); else pass_cnt++;
      tot_cnt++; if (md !== hdr(8'd3, 16'h00A0)) $display("FAIL single_hdr_data got=%h exp=%h", md, hdr(8'd3, 16'h00A0)); else pass_cnt++;
      tot_cnt++; if ({r1, r0} !== 2'b01) $display("FAIL single_hdr_rdy got=%b exp=01", {r1, r0}); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL single_hdr_busy got=%b exp=0", busy); else pass_cnt++;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk); exp = 64'hB0D0_0000_0000_0000 + 64'(i); d0 = exp; #1;
         tot_cnt++; if (mv !== 1'b1 || md !== exp) $display("FAIL single_body%0d got=%b/%h exp=1/%h", i, mv, md, exp); else pass_cnt++;
         tot_cnt++; if ({busy, grant} !== 2'b10) $display("FAIL single_body%0d_state got=%b exp=10", i, {busy, grant}); else pass_cnt++;
      end
      @(negedge clk); v0 = 1'b0; #1;
      tot_cnt++; if ({busy, mv} !== 2'b00) $display("FAIL single_end got=%b exp=00", {busy, mv}); else pass_cnt++;
      @(negedge clk); v0 = 1'b1; v1 = 1'b1; d0 = hdr(8'd0, 16'h00A1); d1 = hdr(8'd0, 16'h00A2); #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00A2)) $display("FAIL single_rr_next got=%h exp=%h", md, hdr(8'd0, 16'h00A2)); else pass_cnt++;
      tot_cnt++; if ({r1, r0} !== 2'b10) $display("FAIL single_rr_rdy got=%b exp=10", {r1, r0}); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_back_to_back;
      rst_n = 1'b0; mr = 1'b1;
      v0 = 1'b1; d0 = hdr(8'd1, 16'h00C0);
      v1 = 1'b1; d1 = hdr(8'd1, 16'h00C1);
      @(negedge clk); rst_n = 1'b1; #1;
      tot_cnt++; if (md !== hdr(8'd1, 16'h00C0)) $display("FAIL b2b_hdr0 got=%h exp=%h", md, hdr(8'd1, 16'h00C0)); else pass_cnt++;
      tot_cnt++; if ({r1, r0} !== 2'b01) $display("FAIL b2b_hdr0_rdy got=%b exp=01", {r1, r0}); else pass_cnt++;
      @(negedge clk); d0 = 64'hB0D0_C0C0_0000_0001; #1;
      tot_cnt++; if (md !== 64'hB0D0_C0C0_0000_0001) $display("FAIL b2b_body0 got=%h exp=b0d0c0c000000001", md); else pass_cnt++;
      tot_cnt++; if ({busy, grant, r1} !== 3'b100) $display("FAIL b2b_body0_state got=%b exp=100", {busy, grant, r1}); else pass_cnt++;
      @(negedge clk); d0 = hdr(8'd1, 16'h00C2); #1;
      tot_cnt++; if (md !== hdr(8'd1, 16'h00C1)) $display("FAIL b2b_hdr1 got=%h exp=%h", md, hdr(8'd1, 16'h00C1)); else pass_cnt++;
      tot_cnt++; if ({r1, r0, busy} !== 3'b100) $display("FAIL b2b_hdr1_rdy got=%b exp=100", {r1, r0, busy}); else pass_cnt++;
      @(negedge clk); d1 = 64'hB0D0_C1C1_0000_0001; #1;
      tot_cnt++; if (md !== 64'hB0D0_C1C1_0000_0001) $display("FAIL b2b_body1 got=%h exp=b0d0c1c100000001", md); else pass_cnt++;
      tot_cnt++; if ({busy, grant, r0} !== 3'b110) $display("FAIL b2b_body1_state got=%b exp=110", {busy, grant, r0}); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; v1 = 1'b0; #1;
      tot_cnt++; if ({busy, mv} !== 2'b00) $display("FAIL b2b_end got=%b exp=00", {busy, mv}); else pass_cnt++;
   endtask

   task automatic test_hold;
      @(negedge clk); v1 = 1'b1; d1 = hdr(8'd0, 16'h00D1); mr = 1'b0; #1;
      tot_cnt++; if (mv !== 1'b1 || md !== hdr(8'd0, 16'h00D1)) $display("FAIL hold_c0 got=%b/%h exp=1/%h", mv, md, hdr(8'd0, 16'h00D1)); else pass_cnt++;
      tot_cnt++; if ({r1, busy} !== 2'b00) $display("FAIL hold_c0_state got=%b exp=00", {r1, busy}); else pass_cnt++;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         if (c == 1) begin v0 = 1'b1; d0 = hdr(8'd0, 16'h00D0); end
         #1;
         tot_cnt++; if (md !== hdr(8'd0, 16'h00D1)) $display("FAIL hold_c%0d_data got=%h exp=%h", c, md, hdr(8'd0, 16'h00D1)); else pass_cnt++;
         tot_cnt++; if ({busy, grant, r0} !== 3'b110) $display("FAIL hold_c%0d_state got=%b exp=110", c, {busy, grant, r0}); else pass_cnt++;
      end
      @(negedge clk); mr = 1'b1; #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00D1)) $display("FAIL hold_accept_data got=%h exp=%h", md, hdr(8'd0, 16'h00D1)); else pass_cnt++;
      tot_cnt++; if ({r1, r0} !== 2'b10) $display("FAIL hold_accept_rdy got=%b exp=10", {r1, r0}); else pass_cnt++;
      @(negedge clk); v1 = 1'b0; #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00D0) || {r1, r0} !== 2'b01) $display("FAIL hold_next got=%h/%b exp=%h/01", md, {r1, r0}, hdr(8'd0, 16'h00D0)); else pass_cnt++;
      @(negedge clk); v0 = 1'b0;
   endtask

   task automatic test_zero_len;
      @(negedge clk); v0 = 1'b1; d0 = hdr(8'd0, 16'h00E0); mr = 1'b1; #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00E0) || {r1, r0} !== 2'b01) $display("FAIL zero_hdr0 got=%h/%b exp=%h/01", md, {r1, r0}, hdr(8'd0, 16'h00E0)); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy0 got=%b exp=0", busy); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; v1 = 1'b1; d1 = hdr(8'd0, 16'h00E1); #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00E1) || {r1, r0} !== 2'b10) $display("FAIL zero_hdr1 got=%h/%b exp=%h/10", md, {r1, r0}, hdr(8'd0, 16'h00E1)); else pass_cnt++;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy1 got=%b exp=0", busy); else pass_cnt++;
      @(negedge clk); v1 = 1'b0; #1;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL zero_busy2 got=%b exp=0", busy); else pass_cnt++;
   endtask

   task automatic test_reset_mid;
      @(negedge clk); v0 = 1'b1; d0 = hdr(8'd0, 16'h00F0); mr = 1'b1;
      @(negedge clk); v0 = 1'b0; v1 = 1'b1; d1 = hdr(8'd3, 16'h00F1); #1;
      tot_cnt++; if (md !== hdr(8'd3, 16'h00F1)) $display("FAIL rmid_hdr got=%h exp=%h", md, hdr(8'd3, 16'h00F1)); else pass_cnt++;
      @(negedge clk); d1 = 64'hB0D0_F1F1_0000_0001; #1;
      tot_cnt++; if ({busy, grant} !== 2'b11) $display("FAIL rmid_body1 got=%b exp=11", {busy, grant}); else pass_cnt++;
      @(negedge clk); d1 = 64'hB0D0_F1F1_0000_0002; #1;
      tot_cnt++; if (mv !== 1'b1 || md !== 64'hB0D0_F1F1_0000_0002) $display("FAIL rmid_body2 got=%b/%h exp=1/b0d0f1f100000002", mv, md); else pass_cnt++;
      rst_n = 1'b0; #1;
      tot_cnt++; if ({mv, r0, r1, busy, grant} !== 5'b0) $display("FAIL rmid_rst got=%b exp=00000", {mv, r0, r1, busy, grant}); else pass_cnt++;
      @(negedge clk); rst_n = 1'b1; v0 = 1'b1; v1 = 1'b1;
      d0 = hdr(8'd0, 16'h00F2); d1 = hdr(8'd0, 16'h00F3); #1;
      tot_cnt++; if (md !== hdr(8'd0, 16'h00F2) || {r1, r0, busy} !== 3'b010) $display("FAIL rmid_after got=%h/%b exp=%h/010", md, {r1, r0, busy}, hdr(8'd0, 16'h00F2)); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; v1 = 1'b0;
   endtask

   task automatic test_bubble;
      @(negedge clk); v0 = 1'b1; d0 = hdr(8'd2, 16'h0077); mr = 1'b1; #1;
      tot_cnt++; if (mv !== 1'b1) $display("FAIL bub_hdr got=%b exp=1", mv); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; #1;
      tot_cnt++; if ({mv, busy, grant} !== 3'b010) $display("FAIL bub_gap got=%b exp=010", {mv, busy, grant}); else pass_cnt++;
      @(negedge clk); v0 = 1'b1; d0 = 64'hB0D0_7777_0000_0001; mr = 1'b0; #1;
      tot_cnt++; if ({mv, r0} !== 2'b10) $display("FAIL bub_stall got=%b exp=10", {mv, r0}); else pass_cnt++;
      @(negedge clk); mr = 1'b1; #1;
      tot_cnt++; if (r0 !== 1'b1 || md !== 64'hB0D0_7777_0000_0001) $display("FAIL bub_body1 got=%b/%h exp=1/b0d0777700000001", r0, md); else pass_cnt++;
      @(negedge clk); d0 = 64'hB0D0_7777_0000_0002; #1;
      tot_cnt++; if ({mv, busy} !== 2'b11) $display("FAIL bub_body2 got=%b exp=11", {mv, busy}); else pass_cnt++;
      @(negedge clk); v0 = 1'b0; #1;
      tot_cnt++; if (busy !== 1'b0) $display("FAIL bub_end got=%b exp=0", busy); else pass_cnt++;
   endtask

`ifdef POLARA_MEM_ARB_STATS_EN
   task automatic test_stats;
      @(negedge clk); rst_n = 1'b0; #1;
      tot_cnt++; if ({pc0, pc1} !== 32'h0) $display("FAIL stats_rst got=%h exp=00000000", {pc0, pc1}); else pass_cnt++;
      @(negedge clk); rst_n = 1'b1; v0 = 1'b1; v1 = 1'b0; d0 = hdr(8'd0, 16'h5555); mr = 1'b1;
      repeat (1000) @(negedge clk);
      #1;
      tot_cnt++; if (pc0 !== 16'd1000) $display("FAIL stats_1000 got=%0d exp=1000", pc0); else pass_cnt++;
      repeat (69000) @(negedge clk);
      #1;
      tot_cnt++; if (pc0 !== 16'hFFFF) $display("FAIL stats_sat got=%h exp=ffff", pc0); else pass_cnt++;
      tot_cnt++; if (pc1 !== 16'h0) $display("FAIL stats_cnt1 got=%h exp=0000", pc1); else pass_cnt++;
      v0 = 1'b0;
   endtask
`endif

   initial begin
      rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; mr = 1'b0; d0 = '0; d1 = '0;
      test_reset;
      test_single;
      test_back_to_back;
      test_hold;
      test_zero_len;
      test_reset_mid;
      test_bubble;
`ifdef POLARA_MEM_ARB_STATS_EN
      test_stats;
`endif
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
